// File: rtl/cater_sched_if.sv
// Client-side bus of the cater scheduler: request and response channels.
//
// Handshake rule for both channels: a transfer happens on a rising clock
// edge where valid and ready are both high. The producer holds valid and
// its payload stable until that edge. The consumer may raise or drop ready
// freely. Request side: the scheduler's req_ready is one-hot or zero.
interface cater_sched_if #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4,
  parameter int IDW   = 2
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_x;
  logic [NREQ*WIDTH-1:0] req_y;
  logic [NREQ-1:0]       req_a;
  logic [NREQ-1:0]       req_b;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [3:0]            rsp_cat;

  // Client side: issues requests and consumes responses.
  modport master (
    output req_valid, req_x, req_y, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_cat
  );

  // Scheduler side.
  modport slave (
    input  req_valid, req_x, req_y, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_cat
  );
endinterface

// File: rtl/cater_sched.sv
// Round-robin scheduler that time-shares one combinational cater datapath
// among NREQ requesters. One transaction at a time: grant, hold operands
// for SETTLE cycles, capture the 4-bit result, return it with the ID.
module cater_sched #(
  parameter int WIDTH  = 8,
  parameter int NREQ   = 4,
  parameter int IDW    = 2,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  cater_sched_if.slave     bus,
  output logic [WIDTH-1:0] dp_x,
  output logic [WIDTH-1:0] dp_y,
  output logic             dp_a,
  output logic             dp_b,
  input  logic [3:0]       dp_cat,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  localparam logic [IDW-1:0] PTR_RST = IDW'(NREQ - 1);
  localparam logic [3:0]     CNT_LD  = 4'(SETTLE - 1);

  logic [1:0]       state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] dp_x_q, dp_x_d;
  logic [WIDTH-1:0] dp_y_q, dp_y_d;
  logic             dp_a_q, dp_a_d;
  logic             dp_b_q, dp_b_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]   rsp_id_q, rsp_id_d;
  logic [3:0]       rsp_cat_q, rsp_cat_d;

  logic             gnt_found;
  logic [IDW-1:0]   gnt_idx;
  logic [IDW-1:0]   cand;

  // Rotating priority search: first valid requester starting at ptr+1.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IDW'((int'(ptr_q) + k) % NREQ);
      if (!gnt_found && bus.req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  // Accept is offered only while idle and out of reset; one-hot at winner.
  assign bus.req_ready = (rst_n && state_q == ST_IDLE && gnt_found) ?
                         (NREQ'(1) << gnt_idx) : '0;

  // Next-state logic for the transaction FSM and all held registers.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    dp_x_d      = dp_x_q;
    dp_y_d      = dp_y_q;
    dp_a_d      = dp_a_q;
    dp_b_d      = dp_b_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_cat_d   = rsp_cat_q;
    case (state_q)
      ST_IDLE: begin
        if (gnt_found) begin
          dp_x_d   = bus.req_x[gnt_idx*WIDTH +: WIDTH];
          dp_y_d   = bus.req_y[gnt_idx*WIDTH +: WIDTH];
          dp_a_d   = bus.req_a[gnt_idx];
          dp_b_d   = bus.req_b[gnt_idx];
          rsp_id_d = gnt_idx;
          ptr_d    = gnt_idx;
          cnt_d    = CNT_LD;
          state_d  = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        // Operands stay on the datapath; capture once the hold time expires.
        if (cnt_q == 4'd0) begin
          rsp_cat_d   = dp_cat;
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        // Result held until the consumer takes it; no grants meanwhile.
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers; reset discards any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ptr_q       <= PTR_RST;
      cnt_q       <= 4'd0;
      dp_x_q      <= '0;
      dp_y_q      <= '0;
      dp_a_q      <= 1'b0;
      dp_b_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_cat_q   <= 4'd0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      dp_x_q      <= dp_x_d;
      dp_y_q      <= dp_y_d;
      dp_a_q      <= dp_a_d;
      dp_b_q      <= dp_b_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_cat_q   <= rsp_cat_d;
    end
  end

  assign dp_x          = dp_x_q;
  assign dp_y          = dp_y_q;
  assign dp_a          = dp_a_q;
  assign dp_b          = dp_b_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_cat   = rsp_cat_q;
  assign busy          = (state_q != ST_IDLE);
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_cater_sched.sv
// Directed bench for cater_sched: one instance with SETTLE=1 for the main
// scenarios, one with SETTLE=3 for the longer hold. The cater datapath is
// replaced by bench-driven dp_cat stubs.
module tb_cater_sched;
  logic clk;
  logic rst_n;

  int total = 0;
  int bad   = 0;

  cater_sched_if #(.WIDTH(8), .NREQ(4), .IDW(2)) if1 ();
  cater_sched_if #(.WIDTH(8), .NREQ(4), .IDW(2)) if3 ();

  logic [7:0] dp_x1, dp_y1, dp_x3, dp_y3;
  logic       dp_a1, dp_b1, dp_a3, dp_b3;
  logic [3:0] dp_cat1, dp_cat3;
  logic       busy1, busy3;
  logic [1:0] st1, st3;

  cater_sched #(.WIDTH(8), .NREQ(4), .IDW(2), .SETTLE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1),
    .dp_x(dp_x1), .dp_y(dp_y1), .dp_a(dp_a1), .dp_b(dp_b1),
    .dp_cat(dp_cat1), .busy(busy1), .dbg_state(st1)
  );

  cater_sched #(.WIDTH(8), .NREQ(4), .IDW(2), .SETTLE(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .bus(if3),
    .dp_x(dp_x3), .dp_y(dp_y3), .dp_a(dp_a3), .dp_b(dp_b3),
    .dp_cat(dp_cat3), .busy(busy3), .dbg_state(st3)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drain1(input string nm);
    int n;
    n = 0;
    while (busy1 !== 1'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (busy1 !== 1'b0) begin
      bad++;
      $display("FAIL %s_drain busy got=%b exp=0", nm, busy1);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    if1.req_valid = 4'b1111;
    #1;
    total++; if (if1.req_ready !== 4'b0000) begin bad++; $display("FAIL rst_req_ready got=%b exp=0000", if1.req_ready); end
    total++; if (busy1 !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy1); end
    total++; if (if1.rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_rsp_valid got=%b exp=0", if1.rsp_valid); end
    total++; if (dp_x1 !== 8'h00) begin bad++; $display("FAIL rst_dp_x got=%h exp=00", dp_x1); end
    // Release, grant req 2 with x=0xAA, then reset mid-SETTLE.
    @(negedge clk);
    rst_n = 1'b1;
    if1.req_valid = 4'b0100;
    if1.req_x[23:16] = 8'hAA;
    if1.rsp_ready = 1'b1;
    #1;
    total++; if (if1.req_ready !== 4'b0100) begin bad++; $display("FAIL rst_grant2_ready got=%b exp=0100", if1.req_ready); end
    @(negedge clk);
    total++; if (st1 !== 2'd1) begin bad++; $display("FAIL rst_mid_state got=%0d exp=1", st1); end
    total++; if (dp_x1 !== 8'hAA) begin bad++; $display("FAIL rst_mid_dp_x got=%h exp=aa", dp_x1); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (busy1 !== 1'b0) begin bad++; $display("FAIL rst_async_busy got=%b exp=0", busy1); end
    total++; if (dp_x1 !== 8'h00) begin bad++; $display("FAIL rst_async_dp_x got=%h exp=00", dp_x1); end
    total++; if (if1.rsp_id !== 2'd0) begin bad++; $display("FAIL rst_async_rsp_id got=%0d exp=0", if1.rsp_id); end
    total++; if (if1.req_ready !== 4'b0000) begin bad++; $display("FAIL rst_async_req_ready got=%b exp=0000", if1.req_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    if1.req_valid = 4'b0000;
    @(negedge clk);
    total++; if (if1.rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_stale_rsp got=%b exp=0", if1.rsp_valid); end
    total++; if (busy1 !== 1'b0) begin bad++; $display("FAIL rst_stale_busy got=%b exp=0", busy1); end
    if1.req_valid = 4'b1111;
    #1;
    total++; if (if1.req_ready !== 4'b0001) begin bad++; $display("FAIL rst_first_grant got=%b exp=0001", if1.req_ready); end
  endtask

  task automatic test_round_robin();
    int exp_g [6] = '{0, 1, 2, 3, 0, 1};
    int cyc;
    int last;
    int waited;
    cyc  = 0;
    last = -1;
    if1.req_valid = 4'b1111;
    for (int g = 0; g < 6; g++) begin
      waited = 0;
      while (if1.req_ready === 4'b0000 && waited < 10) begin
        @(negedge clk);
        cyc++;
        waited++;
      end
      total++;
      if (if1.req_ready !== (4'b0001 << exp_g[g])) begin
        bad++;
        $display("FAIL rr_grant_%0d got=%b exp=%b", g, if1.req_ready, 4'b0001 << exp_g[g]);
      end
      if (g > 0) begin
        total++;
        if (cyc - last != 3) begin
          bad++;
          $display("FAIL rr_spacing_%0d got=%0d exp=3", g, cyc - last);
        end
      end
      last = cyc;
      @(negedge clk);
      cyc++;
    end
    if1.req_valid = 4'b0000;
    drain1("rr");
  endtask

  task automatic test_wrap();
    @(negedge clk);
    if1.req_valid = 4'b1000;
    #1;
    total++; if (if1.req_ready !== 4'b1000) begin bad++; $display("FAIL wrap_req3 got=%b exp=1000", if1.req_ready); end
    @(negedge clk);
    if1.req_valid = 4'b0000;
    drain1("wrap3");
    if1.req_valid = 4'b1010;
    #1;
    total++; if (if1.req_ready !== 4'b0010) begin bad++; $display("FAIL wrap_req1 got=%b exp=0010", if1.req_ready); end
    @(negedge clk);
    if1.req_valid = 4'b0000;
    total++; if (if1.rsp_id !== 2'd1) begin bad++; $display("FAIL wrap_rsp_id got=%0d exp=1", if1.rsp_id); end
    drain1("wrap1");
  endtask

  task automatic test_single();
    @(negedge clk);
    if1.req_valid   = 4'b0010;
    if1.req_x[15:8] = 8'h3C;
    if1.req_y[15:8] = 8'h04;
    if1.req_a       = 4'b0010;
    if1.req_b       = 4'b0000;
    if1.rsp_ready   = 1'b1;
    dp_cat1         = 4'hB;
    #1;
    total++; if (if1.req_ready !== 4'b0010) begin bad++; $display("FAIL single_req_ready got=%b exp=0010", if1.req_ready); end
    @(negedge clk);
    if1.req_valid = 4'b0000;
    total++; if (dp_x1 !== 8'h3C) begin bad++; $display("FAIL single_dp_x got=%h exp=3c", dp_x1); end
    total++; if (dp_y1 !== 8'h04) begin bad++; $display("FAIL single_dp_y got=%h exp=04", dp_y1); end
    total++; if ({dp_a1, dp_b1} !== 2'b10) begin bad++; $display("FAIL single_dp_ab got=%b exp=10", {dp_a1, dp_b1}); end
    total++; if (if1.rsp_valid !== 1'b0) begin bad++; $display("FAIL single_early_rsp got=%b exp=0", if1.rsp_valid); end
    @(negedge clk);
    total++; if (if1.rsp_valid !== 1'b1) begin bad++; $display("FAIL single_rsp_valid got=%b exp=1", if1.rsp_valid); end
    total++; if (if1.rsp_id !== 2'd1) begin bad++; $display("FAIL single_rsp_id got=%0d exp=1", if1.rsp_id); end
    total++; if (if1.rsp_cat !== 4'hB) begin bad++; $display("FAIL single_rsp_cat got=%h exp=b", if1.rsp_cat); end
    @(negedge clk);
    total++; if (st1 !== 2'd0) begin bad++; $display("FAIL single_idle got=%0d exp=0", st1); end
    total++; if (if1.rsp_valid !== 1'b0) begin bad++; $display("FAIL single_rsp_drop got=%b exp=0", if1.rsp_valid); end
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    if1.req_valid  = 4'b0001;
    if1.req_x[7:0] = 8'h55;
    if1.rsp_ready  = 1'b0;
    dp_cat1        = 4'h7;
    #1;
    total++; if (if1.req_ready !== 4'b0001) begin bad++; $display("FAIL bp_grant0 got=%b exp=0001", if1.req_ready); end
    @(negedge clk);
    if1.req_valid = 4'b1110;
    if1.req_x[15:8] = 8'h66;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      total++; if (if1.rsp_valid !== 1'b1) begin bad++; $display("FAIL bp_valid_%0d got=%b exp=1", i, if1.rsp_valid); end
      total++; if (if1.rsp_cat !== 4'h7) begin bad++; $display("FAIL bp_cat_%0d got=%h exp=7", i, if1.rsp_cat); end
      total++; if (if1.rsp_id !== 2'd0) begin bad++; $display("FAIL bp_id_%0d got=%0d exp=0", i, if1.rsp_id); end
      total++; if (if1.req_ready !== 4'b0000) begin bad++; $display("FAIL bp_ready_%0d got=%b exp=0000", i, if1.req_ready); end
      dp_cat1 = 4'(i);
      @(negedge clk);
    end
    if1.rsp_ready = 1'b1;
    @(negedge clk);
    total++; if (if1.rsp_valid !== 1'b0) begin bad++; $display("FAIL bp_release_valid got=%b exp=0", if1.rsp_valid); end
    total++; if (if1.req_ready !== 4'b0010) begin bad++; $display("FAIL bp_next_ready got=%b exp=0010", if1.req_ready); end
    @(negedge clk);
    if1.req_valid = 4'b0000;
    total++; if (busy1 !== 1'b1) begin bad++; $display("FAIL bp_next_busy got=%b exp=1", busy1); end
    total++; if (dp_x1 !== 8'h66) begin bad++; $display("FAIL bp_next_dp_x got=%h exp=66", dp_x1); end
    drain1("bp");
  endtask

  task automatic test_settle3();
    @(negedge clk);
    if3.rsp_ready     = 1'b1;
    if3.req_valid     = 4'b0100;
    if3.req_x[23:16]  = 8'h99;
    if3.req_y[23:16]  = 8'h12;
    if3.req_a         = 4'b0100;
    if3.req_b         = 4'b0100;
    dp_cat3           = 4'h1;
    #1;
    total++; if (if3.req_ready !== 4'b0100) begin bad++; $display("FAIL s3_grant got=%b exp=0100", if3.req_ready); end
    @(negedge clk);
    if3.req_valid = 4'b0000;
    dp_cat3 = 4'h2;
    for (int i = 0; i < 3; i++) begin
      total++; if ({dp_x3, dp_y3, dp_a3, dp_b3} !== {8'h99, 8'h12, 2'b11}) begin bad++; $display("FAIL s3_dp_hold_%0d got=%h/%h/%b%b exp=99/12/11", i, dp_x3, dp_y3, dp_a3, dp_b3); end
      total++; if (if3.rsp_valid !== 1'b0) begin bad++; $display("FAIL s3_early_%0d got=%b exp=0", i, if3.rsp_valid); end
      @(negedge clk);
      dp_cat3 = 4'(3 + i);
    end
    total++; if (if3.rsp_valid !== 1'b1) begin bad++; $display("FAIL s3_valid got=%b exp=1", if3.rsp_valid); end
    total++; if (if3.rsp_cat !== 4'h4) begin bad++; $display("FAIL s3_cat got=%h exp=4", if3.rsp_cat); end
    total++; if (if3.rsp_id !== 2'd2) begin bad++; $display("FAIL s3_id got=%0d exp=2", if3.rsp_id); end
    total++; if (dp_x3 !== 8'h99) begin bad++; $display("FAIL s3_dp_x_end got=%h exp=99", dp_x3); end
    @(negedge clk);
    total++; if (busy3 !== 1'b0) begin bad++; $display("FAIL s3_idle got=%b exp=0", busy3); end
    total++; if (if3.rsp_cat !== 4'h4) begin bad++; $display("FAIL s3_cat_hold got=%h exp=4", if3.rsp_cat); end
  endtask

  initial begin
    rst_n = 1'b0;
    if1.req_valid = '0; if1.req_x = '0; if1.req_y = '0;
    if1.req_a = '0; if1.req_b = '0; if1.rsp_ready = 1'b0;
    if3.req_valid = '0; if3.req_x = '0; if3.req_y = '0;
    if3.req_a = '0; if3.req_b = '0; if3.rsp_ready = 1'b0;
    dp_cat1 = 4'h0;
    dp_cat3 = 4'h0;
    test_reset();
    test_round_robin();
    test_wrap();
    test_single();
    test_backpressure();
    test_settle3();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/cater_sched.md
# cater_sched

Round-robin scheduler sharing one `cater` combinational datapath among `NREQ` requesters. It performs these steps for each transaction:
- accepts one operand set per transaction over a valid/ready handshake;
- drives the operands onto the datapath and holds them for `SETTLE` cycles;
- captures the 4-bit `cat` result and returns it with the requester ID over a second valid/ready handshake.

It sits between the client ports and the `cater` instance, which it fully owns.

## Interface
- `WIDTH`, 8, operand width; must match the `cater` instance.
- `NREQ`, 4, number of requesters; 2..16.
- `IDW`, 2, requester ID width; must be ≥ clog2(`NREQ`).
- `SETTLE`, 1, cycles operands are held before result capture; 1..15.

Ports:
- `clk` in 1: single clock; all state on rising edge.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `req_valid` in `NREQ`: per-requester request valid.
- `req_ready` out `NREQ`: per-requester accept; at most one bit set.
- `req_x` in `NREQ*WIDTH`: x operands; requester i at `[i*WIDTH +: WIDTH]`.
- `req_y` in `NREQ*WIDTH`: y operands, packed the same way.
- `req_a` in `NREQ`: a control bit, one per requester.
- `req_b` in `NREQ`: b control bit, one per requester.
- `dp_x` out `WIDTH`: to `cater.x`.
- `dp_y` out `WIDTH`: to `cater.y`.
- `dp_a` out 1: to `cater.a`.
- `dp_b` out 1: to `cater.b`.
- `dp_cat` in 4: from `cater.cat`.
- `rsp_valid` out 1: result valid.
- `rsp_ready` in 1: consumer accept.
- `rsp_id` out `IDW`: index of the requester owning the result.
- `rsp_cat` out 4: captured result.
- `busy` out 1: high whenever state ≠ IDLE.

## Operation
- FSM states: IDLE, SETTLE, RESP. Reset state: IDLE.
- Arbitration in IDLE:
  - Winner g is the first set `req_valid` bit searching from `ptr+1` upward, wrapping modulo `NREQ`.
  - `req_ready` is one-hot at g, combinational from state and `req_valid`.
  - In SETTLE/RESP, or with no valid request, `req_ready` = 0.
- Grant edge (IDLE with any `req_valid`):
  - `dp_x`/`dp_y`/`dp_a`/`dp_b` ← requester g's operands.
  - `rsp_id` ← g; `ptr` ← g; `cnt` ← `SETTLE`-1.
  - Go to SETTLE.
- SETTLE:
  - `dp_*` held constant.
  - If `cnt` = 0: `rsp_cat` ← `dp_cat`, `rsp_valid` ← 1, go to RESP.
  - Otherwise `cnt` decrements.
- RESP:
  - `rsp_valid`, `rsp_id`, `rsp_cat` held stable until `rsp_valid & rsp_ready`.
  - On that edge: `rsp_valid` ← 0, go to IDLE.
- `dp_*` keep their last values in IDLE and RESP; no change except on a grant edge.
- Requesters must hold `req_valid` and operands until accepted. A `req_valid` deasserted before grant is simply not seen; the block has no error output.
- Reset values:
  - `ptr` = `NREQ`-1, so requester 0 wins first.
  - `dp_x`, `dp_y`, `dp_a`, `dp_b`, `rsp_valid`, `rsp_id`, `rsp_cat`, `cnt` = 0.
  - `busy` = 0, `req_ready` = 0 during reset.
- Reset mid-transaction: the transaction is discarded, no response is produced, and `ptr` returns to `NREQ`-1.

## Timing
- Grant at edge T. `dp_*` valid from T.
- Result captured at edge T+`SETTLE`, so `rsp_valid` is high from T+`SETTLE`.
- If `rsp_ready` is already high: response handshake at T+`SETTLE`+1, next grant earliest at T+`SETTLE`+2.
- Peak throughput: one transaction per `SETTLE`+2 cycles.
- `rsp_ready` high in the first RESP cycle completes on that cycle's edge, with no extra wait state.
- Request asserted during SETTLE/RESP: waits, with `req_ready` low, until IDLE.
- Response backpressure: `rsp_ready` low stalls in RESP indefinitely; no new grants are issued while stalled.
- Fairness: with all requesters continuously valid, grants cycle 0,1,…,`NREQ`-1,0. No requester waits more than `NREQ`-1 other transactions.

## Test plan
- **Reset values.** Assert `rst_n`=0 mid-SETTLE (x=0xAA granted to req 2) → all outputs 0 asynchronously. After release, first grant with all valid goes to req 0, and no stale response appears.
- **Single request, `SETTLE`=1.** req 1 valid, x=0x3C, y=0x04, a=1, b=0, stub `dp_cat`=0xB, `rsp_ready`=1. Required:
  - `req_ready`=0b0010 in the grant cycle;
  - `dp_x`=0x3C from T;
  - `rsp_valid`, `rsp_id`=1, `rsp_cat`=0xB at T+1;
  - IDLE at T+2.
- **Round-robin fairness.** All 4 valid continuously, `rsp_ready`=1 → grant order 0,1,2,3,0,1 at 3-cycle spacing.
- **Wrap-around priority.** After serving req 3, only req 1 and req 3 valid → req 1 granted next.
- **Backpressure.** Hold `rsp_ready`=0 for 5 cycles while RESP → `rsp_valid`/`rsp_cat`/`rsp_id` stable, `req_ready`=0 throughout. Release → response completes, next grant follows one cycle later.
- **`SETTLE`=3.** Stub `dp_cat` changes each cycle → `rsp_cat` equals the `dp_cat` value present at edge T+3, and `dp_*` are unchanged from T to T+3.
